// File: rtl/simple_proc_pkg.sv
// Shared definitions for the simple processor: instruction field layout,
// opcode constants and the fetch-stage state encoding.
package simple_proc_pkg;

  localparam int INST_W = 32;

  // Opcodes carried in INST[31:26]
  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SW   = 6'b000010;
  localparam logic [5:0] OP_SUB  = 6'b000011;
  localparam logic [5:0] OP_LW   = 6'b000100;
  localparam logic [5:0] OP_AND  = 6'b000101;
  localparam logic [5:0] OP_OR   = 6'b000111;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // Instruction field slices: op[31:26] rs[25:21] rt[20:16] rd[15:11]
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  // Extract the opcode field of an instruction word
  function automatic logic [5:0] get_op(input logic [INST_W-1:0] inst);
    return inst[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/inst_rom.sv
// Instruction store: one synchronous write port for program loading and one
// combinational read port for the fetch PC. A read of the address being
// written in the same cycle returns the new data (write-first).
module inst_rom
  import simple_proc_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [INST_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [INST_W-1:0] mem_q [DEPTH];

  // Program load write port
  // NOTE: storage deliberately has no reset; a loaded program survives RST_N.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Combinational read with write-data bypass
  assign rdata = (we && (waddr == raddr)) ? wdata : mem_q[raddr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: program counter, fetch FSM and the registered
// instruction output feeding the datapath. The ROM lives in inst_rom.
module inst_fetch_unit
  import simple_proc_pkg::*;
#(
  parameter int                ADDR_W   = 5,
  parameter logic [5:0]        HALT_OP  = OP_HALT,
  parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              STALL,
  input  logic              LOAD_EN,
  input  logic [ADDR_W-1:0] LOAD_ADDR,
  input  logic [INST_W-1:0] LOAD_DATA,
  output logic [INST_W-1:0] INST,
  output logic              INST_VALID,
  output logic [ADDR_W-1:0] PC,
  output logic              HALTED
);

  // Fetch pointer carries one extra bit so "past the last word" is a distinct
  // value; the visible PC then stays on the last issued address.
  localparam logic [ADDR_W:0] FETCH_ONE = (ADDR_W+1)'(1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W:0]   fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              halted_q, halted_d;

  logic              rom_we;
  logic [INST_W-1:0] rom_rdata;

  // Loads are only accepted while not fetching and never during reset
  assign rom_we = LOAD_EN && RST_N && (state_q != FETCH);

  inst_rom #(
    .ADDR_W(ADDR_W)
  ) u_rom (
    .clk  (CLK),
    .we   (rom_we),
    .waddr(LOAD_ADDR),
    .wdata(LOAD_DATA),
    .raddr(fetch_addr_q[ADDR_W-1:0]),
    .rdata(rom_rdata)
  );

  // Next-state and next-output computation for the fetch FSM
  // NOTE: every target gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    halted_d     = halted_q;

    unique case (state_q)
      IDLE, HALT: begin
        // STALL is irrelevant here; START always arms a run from word 0
        if (START) begin
          state_d      = FETCH;
          fetch_addr_d = '0;
          pc_d         = '0;
          inst_d       = NOP_INST;
          inst_valid_d = 1'b0;
          halted_d     = 1'b0;
        end
      end

      FETCH: begin
        if (STALL) begin
          // Hold everything; only the valid flag drops so the word is not re-counted
          inst_valid_d = 1'b0;
        end else if (fetch_addr_q[ADDR_W]) begin
          // Last ROM word already issued: stop without wrapping
          state_d      = HALT;
          inst_d       = NOP_INST;
          inst_valid_d = 1'b0;
          halted_d     = 1'b1;
        end else if (get_op(rom_rdata) == HALT_OP) begin
          // Halt word is swallowed; PC reports where it sits
          state_d      = HALT;
          pc_d         = fetch_addr_q[ADDR_W-1:0];
          inst_d       = NOP_INST;
          inst_valid_d = 1'b0;
          halted_d     = 1'b1;
        end else begin
          pc_d         = fetch_addr_q[ADDR_W-1:0];
          inst_d       = rom_rdata;
          inst_valid_d = 1'b1;
          fetch_addr_d = fetch_addr_q + FETCH_ONE;
        end
      end

      default: begin
        state_d      = IDLE;
        inst_d       = NOP_INST;
        inst_valid_d = 1'b0;
        halted_d     = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  // NOTE: sequential state uses non-blocking assignments only, so all flops
  // sample the same pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      pc_q         <= '0;
      inst_q       <= NOP_INST;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      halted_q     <= halted_d;
    end
  end

  assign INST       = inst_q;
  assign INST_VALID = inst_valid_q;
  assign PC         = pc_q;
  assign HALTED     = halted_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit. A ROM image plus "run from 0 until
// a halt opcode or the end of memory" rule predicts each program's issued words.
module tb_inst_fetch_unit;

  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic        STALL;
  logic        LOAD_EN;
  logic [4:0]  LOAD_ADDR;
  logic [31:0] LOAD_DATA;
  logic [31:0] INST;
  logic        INST_VALID;
  logic [4:0]  PC;
  logic        HALTED;

  int checks = 0;
  int errors = 0;

  logic [31:0] rom_model [DEPTH];
  logic [31:0] exp_q [$];
  int          exp_halt_pc;

  inst_fetch_unit #(.ADDR_W(AW)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .STALL     (STALL),
    .LOAD_EN   (LOAD_EN),
    .LOAD_ADDR (LOAD_ADDR),
    .LOAD_DATA (LOAD_DATA),
    .INST      (INST),
    .INST_VALID(INST_VALID),
    .PC        (PC),
    .HALTED    (HALTED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected program: words from address 0 until a halt opcode or end of memory
  function automatic void build_expected();
    exp_q.delete();
    exp_halt_pc = DEPTH - 1;
    for (int a = 0; a < DEPTH; a++) begin
      if (rom_model[a][31:26] == 6'b111111) begin
        exp_halt_pc = a;
        return;
      end
      exp_q.push_back(rom_model[a]);
    end
  endfunction

  function automatic logic [31:0] rand_non_halt();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'b111111) w[31:26] = 6'b000001;
    return w;
  endfunction

  // ROM write while the unit is idle or halted
  task automatic load_word(input logic [4:0] a, input logic [31:0] d);
    LOAD_EN = 1'b1; LOAD_ADDR = a; LOAD_DATA = d;
    tick();
    LOAD_EN = 1'b0;
    rom_model[a] = d;
  endtask

  task automatic wait_halted(input string tag, input int exp_pc);
    bit seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      tick();
      if (HALTED === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || PC !== exp_pc[4:0]) begin
      errors++;
      $display("FAIL %s_halt: halted=%0b pc=%0d, required halted=1 pc=%0d", tag, HALTED, PC, exp_pc);
    end
  endtask

  // Start a run (optionally loading a word in the START cycle) and compare every
  // issued word against the model; rand_mode adds random STALL and stray START.
  task automatic run_check(input string tag, input bit rand_mode, input bit do_load,
                           input logic [4:0] la, input logic [31:0] ld);
    int          idx = 0;
    bit          done = 0;
    bit          stl;
    logic [31:0] prev_inst;
    logic [4:0]  prev_pc;
    if (do_load) rom_model[la] = ld;
    build_expected();
    START = 1'b1; STALL = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
    LOAD_EN = do_load; LOAD_ADDR = la; LOAD_DATA = ld;
    tick();
    START = 1'b0; LOAD_EN = 1'b0;
    checks++;
    if (HALTED !== 1'b0 || PC !== 5'd0) begin
      errors++;
      $display("FAIL %s_start: halted=%0b pc=%0d, required halted=0 pc=0", tag, HALTED, PC);
    end
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      stl = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
      STALL = stl;
      START = rand_mode ? ($urandom_range(0, 7) == 0) : 1'b0;
      prev_inst = INST; prev_pc = PC;
      tick();
      checks++;
      if (stl) begin
        if (INST_VALID !== 1'b0 || INST !== prev_inst || PC !== prev_pc || HALTED !== 1'b0) begin
          errors++;
          $display("FAIL %s_stall: valid=%0b inst=%h pc=%0d halted=%0b, required 0 %h %0d 0",
                   tag, INST_VALID, INST, PC, HALTED, prev_inst, prev_pc);
        end
      end else if (INST_VALID === 1'b1) begin
        if (idx >= exp_q.size()) begin
          errors++;
          $display("FAIL %s_extra: word %h at pc=%0d, required no more than %0d words",
                   tag, INST, PC, exp_q.size());
        end else if (INST !== exp_q[idx] || PC !== idx[4:0]) begin
          errors++;
          $display("FAIL %s_word%0d: inst=%h pc=%0d, required inst=%h pc=%0d",
                   tag, idx, INST, PC, exp_q[idx], idx);
        end
        idx++;
      end else if (HALTED === 1'b1) begin
        done = 1;
      end else begin
        errors++;
        $display("FAIL %s_gap: un-stalled cycle with valid=%0b halted=%0b, required a word or halt",
                 tag, INST_VALID, HALTED);
      end
    end
    START = 1'b0; STALL = 1'b0;
    checks++;
    if (!done || idx != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: halted=%0b words=%0d, required halted=1 words=%0d",
               tag, done, idx, exp_q.size());
    end
    checks++;
    if (PC !== exp_halt_pc[4:0] || INST !== 32'h0 || INST_VALID !== 1'b0) begin
      errors++;
      $display("FAIL %s_haltstate: pc=%0d inst=%h valid=%0b, required pc=%0d inst=00000000 valid=0",
               tag, PC, INST, INST_VALID, exp_halt_pc);
    end
    // STALL has no effect in HALT
    STALL = 1'b1;
    tick();
    STALL = 1'b0;
    checks++;
    if (HALTED !== 1'b1 || PC !== exp_halt_pc[4:0] || INST_VALID !== 1'b0) begin
      errors++;
      $display("FAIL %s_haltstall: halted=%0b pc=%0d valid=%0b, required 1 %0d 0",
               tag, HALTED, PC, INST_VALID, exp_halt_pc);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; START = 1'b1; STALL = 1'b1; LOAD_EN = 1'b0;
    LOAD_ADDR = '0; LOAD_DATA = '0;
    tick(); tick();
    checks++;
    if (INST !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h, required 00000000", INST); end
    checks++;
    if (INST_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, required 0", INST_VALID); end
    checks++;
    if (PC !== 5'd0) begin errors++; $display("FAIL reset_pc: got %0d, required 0", PC); end
    checks++;
    if (HALTED !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b, required 0", HALTED); end
    RST_N = 1'b1; START = 1'b0; STALL = 1'b0;
    tick();
    checks++;
    if (INST_VALID !== 1'b0 || HALTED !== 1'b0 || PC !== 5'd0) begin
      errors++;
      $display("FAIL reset_idle: valid=%0b halted=%0b pc=%0d, required 0 0 0", INST_VALID, HALTED, PC);
    end
  endtask

  task automatic test_program();
    load_word(5'd0, 32'h0441_0800);
    load_word(5'd1, 32'h0443_0800);
    load_word(5'd2, 32'h0C43_0800);
    load_word(5'd3, 32'hFC00_0000);
    run_check("prog", 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_stall();
    bit found = 0;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (INST_VALID === 1'b1 && PC === 5'd1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stall_reach: pc=%0d valid=%0b, required valid word at pc=1", PC, INST_VALID);
    end else begin
      STALL = 1'b1;
      for (int i = 0; i < 2; i++) begin
        tick();
        checks++;
        if (INST !== 32'h0443_0800 || INST_VALID !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold%0d: inst=%h valid=%0b, required 04430800 0", i, INST, INST_VALID);
        end
      end
      STALL = 1'b0;
      tick();
      checks++;
      if (INST !== 32'h0C43_0800 || INST_VALID !== 1'b1 || PC !== 5'd2) begin
        errors++;
        $display("FAIL stall_release: inst=%h valid=%0b pc=%0d, required 0c430800 1 2", INST, INST_VALID, PC);
      end
    end
    STALL = 1'b0;
    wait_halted("stall", 3);
    for (int r = 0; r < 3; r++) run_check("stall_rand", 1'b1, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_full_rom();
    for (int a = 0; a < DEPTH; a++) load_word(a[4:0], rand_non_halt());
    run_check("full", 1'b0, 1'b0, 5'd0, 32'h0);
    run_check("full_rand", 1'b1, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_load_rules();
    load_word(5'd5, 32'hFC00_0000);
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    // Write attempt while fetching must be dropped
    LOAD_EN = 1'b1; LOAD_ADDR = 5'd2; LOAD_DATA = 32'hDEAD_BEEF;
    tick();
    LOAD_EN = 1'b0;
    wait_halted("fetchload", 5);
    run_check("after_fetchload", 1'b0, 1'b0, 5'd0, 32'h0);
    // Same write in HALT is honoured
    load_word(5'd2, 32'hDEAD_BEEF);
    run_check("halt_load", 1'b0, 1'b0, 5'd0, 32'h0);
    // Load and START together: write-first, new word 0 is fetched
    run_check("load_start", 1'b0, 1'b1, 5'd0, rand_non_halt());
    run_check("load_start_rand", 1'b1, 1'b1, 5'd4, rand_non_halt());
  endtask

  task automatic test_reset_mid_fetch();
    bit found = 0;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (INST_VALID === 1'b1 && PC === 5'd2) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rstmid_reach: pc=%0d valid=%0b, required valid word at pc=2", PC, INST_VALID);
    end
    RST_N = 1'b0; START = 1'b1;
    tick();
    RST_N = 1'b1; START = 1'b0;
    checks++;
    if (INST !== 32'h0 || INST_VALID !== 1'b0 || PC !== 5'd0 || HALTED !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state: inst=%h valid=%0b pc=%0d halted=%0b, required 00000000 0 0 0",
               INST, INST_VALID, PC, HALTED);
    end
    tick();
    checks++;
    if (INST_VALID !== 1'b0 || PC !== 5'd0) begin
      errors++;
      $display("FAIL rstmid_idle: valid=%0b pc=%0d, required 0 0", INST_VALID, PC);
    end
    run_check("post_reset", 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b0; STALL = 1'b0; LOAD_EN = 1'b0;
    LOAD_ADDR = '0; LOAD_DATA = '0;
    test_reset();
    test_program();
    test_stall();
    test_full_rom();
    test_load_rules();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
